// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB register: drives a req/ack data-memory port, stalls upstream while an
// access is outstanding and registers the write-back value. MEM_TIMEOUT_EN adds an access timeout.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`DSIZE-1:0] aluout_in,
  input  logic [`DSIZE-1:0] rdata2_in,
  input  logic [`ASIZE-1:0] waddr_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              memtoreg_in,
  input  logic              wen_in,
  input  logic              jal_in,
  input  logic [`ISIZE-1:0] nPC_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [`DSIZE-1:0] dmem_addr,
  output logic [`DSIZE-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [`DSIZE-1:0] dmem_rdata,
  output logic              stall,
  output logic [`DSIZE-1:0] wb_data_out,
  output logic [`ASIZE-1:0] waddr_out,
  output logic              wen_out,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DW = `DSIZE;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic            mem_op;
  logic            timeout;
  logic            advance;
  logic [DW-1:0]   npc_ext;
  logic [DW-1:0]   wb_next;

  assign mem_op     = memread_in | memwrite_in;
  assign dmem_we    = memwrite_in;
  assign dmem_addr  = aluout_in;
  assign dmem_wdata = rdata2_in;
  assign npc_ext    = DW'(nPC_in);

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // An ack on the timeout cycle wins, so the timeout only fires without one.
  assign timeout = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES)) && !dmem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      if (state == S_IDLE) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + TW'(1);
      if (timeout) mem_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Request is withdrawn at once while reset is asserted.
  always_comb begin
    dmem_req = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE:  dmem_req = mem_op;
        S_WAIT:  dmem_req = !timeout;
        default: dmem_req = 1'b0;
      endcase
    end
  end

  assign stall   = dmem_req & ~dmem_ack;
  assign advance = dmem_req ? dmem_ack : (state == S_IDLE);
  assign wb_next = jal_in ? npc_ext :
                   (memtoreg_in & memread_in) ? dmem_rdata : aluout_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (stall) state <= S_WAIT;
        S_WAIT:  if ((dmem_req && dmem_ack) || timeout) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: loads on completion, otherwise a bubble with data held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_out <= '0;
      waddr_out   <= '0;
      wen_out     <= 1'b0;
    end else if (advance) begin
      wb_data_out <= wb_next;
      waddr_out   <= waddr_in;
      wen_out     <= wen_in;
    end else begin
      wen_out     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; timeout scenarios run when MEM_TIMEOUT_EN is defined.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module tb_mem_access_stage;

  localparam int TMO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [`DSIZE-1:0] aluout_in, rdata2_in, dmem_rdata;
  logic [`ASIZE-1:0] waddr_in;
  logic              memread_in, memwrite_in, memtoreg_in, wen_in, jal_in;
  logic [`ISIZE-1:0] nPC_in;
  logic              dmem_req, dmem_we, dmem_ack, stall, wen_out, mem_err;
  logic [`DSIZE-1:0] dmem_addr, dmem_wdata, wb_data_out;
  logic [`ASIZE-1:0] waddr_out;
  logic [31:0]       stall_cnt;

  typedef struct packed {
    logic [`DSIZE-1:0] data;
    logic [`ASIZE-1:0] addr;
    logic              wen;
  } wb_t;

  wb_t         exp_q[$];
  int          assert_count = 0;
  int          fail_count   = 0;
  logic [31:0] exp_stall_cnt = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .aluout_in(aluout_in), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
    .wen_in(wen_in), .jal_in(jal_in), .nPC_in(nPC_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_data_out(wb_data_out), .waddr_out(waddr_out), .wen_out(wen_out),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    aluout_in = '0; rdata2_in = '0; waddr_in = '0; nPC_in = '0;
    memread_in = 0; memwrite_in = 0; memtoreg_in = 0; wen_in = 0; jal_in = 0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_wb_data", wb_data_out, 0);
    checkOutput("rst_waddr", waddr_out, 0);
    checkOutput("rst_wen", wen_out, 0);
    checkOutput("rst_mem_err", mem_err, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    clearInputs();
    rst = 0;
    #1 checkResetValues();
    @(negedge clk);
    rst = 1;
    exp_stall_cnt = 0;
  endtask

  // Drive one EXE/MEM instruction; memory acks after 'delay' extra cycles.
  task automatic applyStimulus(input logic rd, input logic wr, input logic m2r, input logic wen,
                               input logic jal, input logic [31:0] alu, input logic [31:0] rd2,
                               input logic [4:0] waddr, input logic [31:0] npc,
                               input int delay, input logic [31:0] rdata);
    wb_t  e;
    wb_t  got;
    logic mem_op;
    @(negedge clk);
    memread_in = rd; memwrite_in = wr; memtoreg_in = m2r; wen_in = wen; jal_in = jal;
    aluout_in = alu; rdata2_in = rd2; waddr_in = waddr; nPC_in = npc;
    dmem_rdata = rdata; dmem_ack = (delay == 0);
    mem_op = rd | wr;
    e.data = jal ? npc : (m2r & rd) ? rdata : alu;
    e.addr = waddr;
    e.wen  = wen;
    exp_q.push_back(e);
    #1;
    checkOutput("req_first", dmem_req, mem_op);
    checkOutput("stall_first", stall, mem_op && delay > 0);
    if (mem_op) begin
      checkOutput("we_first", dmem_we, wr);
      checkOutput("addr_first", dmem_addr, alu);
      checkOutput("wdata_first", dmem_wdata, rd2);
    end
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk);
      #1 checkOutput("bubble_wen", wen_out, 0);
      @(negedge clk);
      dmem_ack = (k == delay);
      #1;
      checkOutput("req_wait", dmem_req, 1);
      checkOutput("stall_wait", stall, k != delay);
      checkOutput("we_wait", dmem_we, wr);
      checkOutput("addr_wait", dmem_addr, alu);
      checkOutput("wdata_wait", dmem_wdata, rd2);
    end
    @(posedge clk);
    #1;
    exp_stall_cnt += 32'(delay);
    checkOutput("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got.data = wb_data_out; got.addr = waddr_out; got.wen = wen_out;
      checkOutput("wb_data", got.data, e.data);
      checkOutput("wb_waddr", got.addr, e.addr);
      checkOutput("wb_wen", got.wen, e.wen);
    end
    checkOutput("stall_cnt", stall_cnt, exp_stall_cnt);
  endtask

  initial begin
    clearInputs();
    rst = 0;
    #1 checkResetValues();
    repeat (2) @(negedge clk);
    rst = 1;

    // Reset asserted in the middle of an outstanding load
    @(negedge clk);
    memread_in = 1; memtoreg_in = 1; wen_in = 1; aluout_in = 32'h60; waddr_in = 5'd9;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("mid_wait_req", dmem_req, 1);
    #1 rst = 0;
    #1 checkResetValues();
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    rst = 1;
    exp_stall_cnt = 0;

    applyStimulus(0, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 1, 1, 0, 32'h40, 32'h0, 5'd7, 32'h0, 0, 32'hBEEF);
    applyStimulus(1, 0, 1, 1, 0, 32'h44, 32'h0, 5'd8, 32'h0, 3, 32'hCAFE);
    applyStimulus(0, 1, 0, 0, 0, 32'h48, 32'hA5A5, 5'd3, 32'h0, 2, 32'h0);
    applyStimulus(0, 0, 0, 1, 1, 32'h999, 32'h0, 5'd31, 32'h0010, 0, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 32'h55, 32'h0, 5'd2, 32'h0, 0, 32'hDEAD);
    applyStimulus(1, 1, 1, 1, 0, 32'h4C, 32'h77, 5'd4, 32'h0, 1, 32'h1357);
    applyStimulus(1, 0, 1, 1, 1, 32'h50, 32'h0, 5'd30, 32'h0088, 1, 32'h2468);

`ifdef MEM_TIMEOUT_EN
    // Load that is never acknowledged: abandoned after TMO wait cycles
    @(negedge clk);
    memread_in = 1; memtoreg_in = 1; wen_in = 1; aluout_in = 32'h80; waddr_in = 5'd12;
    dmem_ack = 0;
    #1 checkOutput("tmo_req0", dmem_req, 1);
    for (int k = 1; k <= TMO + 1; k++) begin
      @(posedge clk);
      #1 checkOutput("tmo_bubble", wen_out, 0);
      @(negedge clk);
      #1;
      checkOutput("tmo_req", dmem_req, k <= TMO);
      checkOutput("tmo_stall", stall, k <= TMO);
    end
    @(posedge clk);
    #1;
    exp_stall_cnt += 32'(TMO + 1);
    checkOutput("tmo_mem_err", mem_err, 1);
    checkOutput("tmo_no_wb", wen_out, 0);
    checkOutput("tmo_stall_cnt", stall_cnt, exp_stall_cnt);
    @(negedge clk);
    clearInputs();
    @(posedge clk);
    #1 checkOutput("tmo_sticky", mem_err, 1);
    pulseReset();
    // Ack arriving on the timeout cycle completes normally
    applyStimulus(1, 0, 1, 1, 0, 32'h84, 32'h0, 5'd13, 32'h0, TMO + 1, 32'h600D);
    checkOutput("tmo_ack_wins", mem_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
